ascon_ctrl_fsm: RTL and testbench
=================================

Name: ascon_ctrl_fsm

Overview:
- Control sequencer for the ASCON-128 permutation datapath: drives round index, state-register enable, input mux select, and begin/end XOR controls for one encryption.
- Phase order: initialization, one associated-data block, plaintext blocks, finalization.
- Exchanges handshakes with the host (start, per-block data valid/ready) and flags ciphertext and tag availability.
- Sits between top-level I/O and the permutation datapath; it is the initiator side of that datapath's control interface.

Parameters:
- NB_BLOCKS, default 4: number of plaintext blocks per message (≥1). Last block is absorbed in finalization.

Ports:
- clock_i, in, 1: system clock, rising edge.
- resetb_i, in, 1: asynchronous, active-high reset (1 = reset).
- start_i, in, 1: start encryption; sampled only in IDLE.
- data_valid_i, in, 1: host block valid; sampled only in WAIT_AD/WAIT_PT.
- data_ready_o, out, 1: high in WAIT_AD/WAIT_PT.
- round_o, out, 4: round index to constant-add.
- enable_o, out, 1: state register enable.
- input_mode_o, out, 1: 0 = load external state, 1 = loop.
- en_xor_begin_data_o, out, 1: XOR data block into rate before round.
- en_xor_begin_key_o, out, 1: XOR key into capacity before round.
- bypass_xor_end_o, out, 1: 1 = no XOR after round.
- mode_xor_key_o, out, 1: 1 = XOR key into low 128 bits; 0 = XOR 1 into LSB (domain separation).
- cipher_valid_o, out, 1: ciphertext valid at datapath XOR-begin output this cycle.
- tag_valid_o, out, 1: tag valid at datapath state output this cycle.
- busy_o, out, 1: high in any state except IDLE.

Behaviour:
- States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE.
- 4-bit round counter rc; block counter bc, width clog2(NB_BLOCKS)+1.
- Outputs are Moore functions of state, rc, bc.
- Reset (async, any time, including mid-operation): state = IDLE, rc = 0, bc = 0.
  - Reset values: all outputs 0, except bypass_xor_end_o = 1.
- Default outside listed cases: enable_o = 0, bypass_xor_end_o = 1, all other controls 0.
- IDLE:
  - start_i = 1 → INIT with rc = 0; bc cleared.
- INIT (12 cycles, rc 0..11):
  - enable_o = 1, round_o = rc.
  - input_mode_o = 0 when rc = 0, otherwise 1.
  - rc = 11: bypass_xor_end_o = 0, mode_xor_key_o = 1.
  - Exit → WAIT_AD.
- WAIT_AD:
  - data_ready_o = 1; hold until data_valid_i = 1.
  - On valid → AD with rc = 6.
- AD (6 cycles, rc 6..11):
  - enable_o = 1, input_mode_o = 1, round_o = rc.
  - rc = 6: en_xor_begin_data_o = 1.
  - rc = 11: bypass_xor_end_o = 0, mode_xor_key_o = 0.
  - Exit → WAIT_PT.
- WAIT_PT:
  - data_ready_o = 1; hold until data_valid_i = 1.
  - On valid with bc < NB_BLOCKS-1 → PT (rc = 6).
  - On valid with bc = NB_BLOCKS-1 → FINAL (rc = 0).
- PT (6 cycles, rc 6..11):
  - enable_o = 1, input_mode_o = 1.
  - rc = 6: en_xor_begin_data_o = 1, cipher_valid_o = 1.
  - Exit: bc += 1 → WAIT_PT.
- FINAL (12 cycles, rc 0..11):
  - enable_o = 1, input_mode_o = 1.
  - rc = 0: en_xor_begin_data_o = 1, en_xor_begin_key_o = 1, cipher_valid_o = 1.
  - rc = 11: bypass_xor_end_o = 0, mode_xor_key_o = 1.
  - Exit → DONE.
- DONE (1 cycle):
  - tag_valid_o = 1 (register captured the final state at the entry edge).
  - → IDLE.
- NB_BLOCKS = 1: first WAIT_PT goes directly to FINAL; no PT state visited.
- start_i ignored outside IDLE, including DONE; start_i held high re-triggers only from IDLE.
- data_valid_i ignored outside WAIT states; a valid asserted during rounds is not queued.
- rc never wraps past 11; it is reloaded on every phase entry.

Test Plan:
- Reset mid-FINAL (rc = 5) → next cycle: state IDLE, enable_o = 0, busy_o = 0, bypass_xor_end_o = 1; new start runs a full sequence correctly.
- NB_BLOCKS = 4, start at cycle 0, data_valid_i tied high:
  - INIT cycles 1-12 (input_mode_o = 0 only at cycle 1; key end-XOR at cycle 12).
  - data_ready_o at cycles 13, 20, 27, 34, 41.
  - cipher_valid_o at cycles 21, 28, 35, 42.
  - tag_valid_o at cycle 54; busy_o low at cycle 55.
- data_valid_i withheld 5 cycles in WAIT_AD → data_ready_o high 6 cycles, enable_o = 0 throughout, AD begins the cycle after valid.
- NB_BLOCKS = 1 → after AD, single WAIT_PT then FINAL; exactly one cipher_valid_o pulse, coincident with en_xor_begin_key_o = 1.
- Round index check: AD/PT round_o sequence 6,7,8,9,10,11; INIT/FINAL 0..11; domain-separation (bypass_xor_end_o = 0, mode_xor_key_o = 0) only at AD rc = 11.
- Pulse start_i during PT and data_valid_i during INIT → no state change, no extra cipher_valid_o.

Source files
------------

// File: rtl/ascon_ctrl_fsm.sv
// Control sequencer for the ASCON-128 permutation datapath.
// Steps INIT -> AD -> PT blocks -> FINAL and drives round index and the XOR and enable controls.
module ascon_ctrl_fsm #(
  parameter int unsigned NB_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       enable_o,
  output logic       input_mode_o,
  output logic       en_xor_begin_data_o,
  output logic       en_xor_begin_key_o,
  output logic       bypass_xor_end_o,
  output logic       mode_xor_key_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  localparam int unsigned BC_W    = $clog2(NB_BLOCKS) + 1;
  localparam logic [3:0]  RC_LAST = 4'd11;
  localparam logic [3:0]  RC_HALF = 4'd6;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      rc, rc_nxt;
  logic [BC_W-1:0] bc, bc_nxt;

  logic       data_ready_c, enable_c, input_mode_c, xor_data_c, xor_key_c;
  logic       bypass_c, mode_key_c, cipher_valid_c, tag_valid_c, busy_c;
  logic [3:0] round_c;

  // Next state and counters; rc is reloaded on every phase entry.
  always_comb begin
    state_nxt = state;
    rc_nxt    = rc;
    bc_nxt    = bc;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_INIT;
          rc_nxt    = 4'd0;
          bc_nxt    = '0;
        end
      end
      S_INIT: begin
        if (rc == RC_LAST) begin
          state_nxt = S_WAIT_AD;
          rc_nxt    = 4'd0;
        end else begin
          rc_nxt = rc + 4'd1;
        end
      end
      S_WAIT_AD: begin
        if (data_valid_i) begin
          state_nxt = S_AD;
          rc_nxt    = RC_HALF;
        end
      end
      S_AD: begin
        if (rc == RC_LAST) begin
          state_nxt = S_WAIT_PT;
          rc_nxt    = 4'd0;
        end else begin
          rc_nxt = rc + 4'd1;
        end
      end
      S_WAIT_PT: begin
        if (data_valid_i) begin
          if (bc == BC_LAST) begin
            state_nxt = S_FINAL;
            rc_nxt    = 4'd0;
          end else begin
            state_nxt = S_PT;
            rc_nxt    = RC_HALF;
          end
        end
      end
      S_PT: begin
        if (rc == RC_LAST) begin
          state_nxt = S_WAIT_PT;
          rc_nxt    = 4'd0;
          bc_nxt    = bc + BC_W'(1);
        end else begin
          rc_nxt = rc + 4'd1;
        end
      end
      S_FINAL: begin
        if (rc == RC_LAST) begin
          state_nxt = S_DONE;
          rc_nxt    = 4'd0;
        end else begin
          rc_nxt = rc + 4'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore decode of the upcoming state so the registered outputs line up with it.
  always_comb begin
    data_ready_c   = 1'b0;
    round_c        = 4'd0;
    enable_c       = 1'b0;
    input_mode_c   = 1'b0;
    xor_data_c     = 1'b0;
    xor_key_c      = 1'b0;
    bypass_c       = 1'b1;
    mode_key_c     = 1'b0;
    cipher_valid_c = 1'b0;
    tag_valid_c    = 1'b0;
    busy_c         = (state_nxt != S_IDLE);
    case (state_nxt)
      S_INIT: begin
        enable_c     = 1'b1;
        round_c      = rc_nxt;
        input_mode_c = (rc_nxt != 4'd0);
        if (rc_nxt == RC_LAST) begin
          bypass_c   = 1'b0;
          mode_key_c = 1'b1;
        end
      end
      S_WAIT_AD, S_WAIT_PT: data_ready_c = 1'b1;
      S_AD: begin
        enable_c     = 1'b1;
        input_mode_c = 1'b1;
        round_c      = rc_nxt;
        xor_data_c   = (rc_nxt == RC_HALF);
        // Domain separation: XOR 1 into the LSB after the last AD round.
        if (rc_nxt == RC_LAST) bypass_c = 1'b0;
      end
      S_PT: begin
        enable_c       = 1'b1;
        input_mode_c   = 1'b1;
        round_c        = rc_nxt;
        xor_data_c     = (rc_nxt == RC_HALF);
        cipher_valid_c = (rc_nxt == RC_HALF);
      end
      S_FINAL: begin
        enable_c     = 1'b1;
        input_mode_c = 1'b1;
        round_c      = rc_nxt;
        if (rc_nxt == 4'd0) begin
          xor_data_c     = 1'b1;
          xor_key_c      = 1'b1;
          cipher_valid_c = 1'b1;
        end
        if (rc_nxt == RC_LAST) begin
          bypass_c   = 1'b0;
          mode_key_c = 1'b1;
        end
      end
      S_DONE:  tag_valid_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or posedge resetb_i) begin
    if (resetb_i) begin
      state               <= S_IDLE;
      rc                  <= 4'd0;
      bc                  <= '0;
      data_ready_o        <= 1'b0;
      round_o             <= 4'd0;
      enable_o            <= 1'b0;
      input_mode_o        <= 1'b0;
      en_xor_begin_data_o <= 1'b0;
      en_xor_begin_key_o  <= 1'b0;
      bypass_xor_end_o    <= 1'b1;
      mode_xor_key_o      <= 1'b0;
      cipher_valid_o      <= 1'b0;
      tag_valid_o         <= 1'b0;
      busy_o              <= 1'b0;
    end else begin
      state               <= state_nxt;
      rc                  <= rc_nxt;
      bc                  <= bc_nxt;
      data_ready_o        <= data_ready_c;
      round_o             <= round_c;
      enable_o            <= enable_c;
      input_mode_o        <= input_mode_c;
      en_xor_begin_data_o <= xor_data_c;
      en_xor_begin_key_o  <= xor_key_c;
      bypass_xor_end_o    <= bypass_c;
      mode_xor_key_o      <= mode_key_c;
      cipher_valid_o      <= cipher_valid_c;
      tag_valid_o         <= tag_valid_c;
      busy_o              <= busy_c;
    end
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: NB_BLOCKS=4 and NB_BLOCKS=1 instances against a phase-list model.
module tb_ascon_ctrl_fsm;

  localparam int K_INIT = 0, K_WAIT = 1, K_AD = 2, K_PT = 3, K_FINAL = 4, K_DONE = 5;
  localparam logic [13:0] IDLE_VEC = 14'h0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic valid = 1'b0;

  logic       rdy4, en4, im4, xd4, xk4, byp4, mk4, cv4, tv4, bsy4;
  logic [3:0] rnd4;
  logic       rdy1, en1, im1, xd1, xk1, byp1, mk1, cv1, tv1, bsy1;
  logic [3:0] rnd1;
  logic [13:0] v4, v1;

  int checks = 0;
  int errors = 0;

  logic [13:0] log4 [0:63];
  logic [13:0] log1 [0:63];

  // Model: position in the phase list of the current message, per instance.
  bit act [2];
  int m_idx [2];
  int m_pos [2];
  int nbv [2];

  always #5 clk = ~clk;

  ascon_ctrl_fsm #(.NB_BLOCKS(4)) dut4 (
    .clock_i(clk), .resetb_i(rst), .start_i(start), .data_valid_i(valid),
    .data_ready_o(rdy4), .round_o(rnd4), .enable_o(en4), .input_mode_o(im4),
    .en_xor_begin_data_o(xd4), .en_xor_begin_key_o(xk4), .bypass_xor_end_o(byp4),
    .mode_xor_key_o(mk4), .cipher_valid_o(cv4), .tag_valid_o(tv4), .busy_o(bsy4)
  );

  ascon_ctrl_fsm #(.NB_BLOCKS(1)) dut1 (
    .clock_i(clk), .resetb_i(rst), .start_i(start), .data_valid_i(valid),
    .data_ready_o(rdy1), .round_o(rnd1), .enable_o(en1), .input_mode_o(im1),
    .en_xor_begin_data_o(xd1), .en_xor_begin_key_o(xk1), .bypass_xor_end_o(byp1),
    .mode_xor_key_o(mk1), .cipher_valid_o(cv1), .tag_valid_o(tv1), .busy_o(bsy1)
  );

  assign v4 = {rdy4, rnd4, en4, im4, xd4, xk4, byp4, mk4, cv4, tv4, bsy4};
  assign v1 = {rdy1, rnd1, en1, im1, xd1, xk1, byp1, mk1, cv1, tv1, bsy1};

  // Message = INIT, WAIT, AD, (WAIT, PT) x (nb-1), WAIT, FINAL, DONE.
  function automatic int seg_kind(input int idx, input int nb);
    int wait_fin;
    wait_fin = 3 + 2 * (nb - 1);
    if (idx == 0) return K_INIT;
    if (idx == 1) return K_WAIT;
    if (idx == 2) return K_AD;
    if (idx < wait_fin) return (((idx - 3) % 2) == 0) ? K_WAIT : K_PT;
    if (idx == wait_fin) return K_WAIT;
    if (idx == wait_fin + 1) return K_FINAL;
    return K_DONE;
  endfunction

  function automatic int seg_len(input int k);
    case (k)
      K_INIT, K_FINAL: return 12;
      K_AD, K_PT:      return 6;
      default:         return 1;
    endcase
  endfunction

  function automatic logic [13:0] exp_vec(input bit a, input int k, input int pos);
    logic rounds, last, rdy, en, im, xd, xk, byp, mk, cv, tv;
    logic [3:0] rnd;
    int first;
    if (!a) return IDLE_VEC;
    rounds = (k == K_INIT || k == K_AD || k == K_PT || k == K_FINAL);
    first  = (k == K_AD || k == K_PT) ? 6 : 0;
    last   = rounds && (pos == seg_len(k) - 1);
    rdy    = (k == K_WAIT);
    rnd    = rounds ? 4'(first + pos) : 4'd0;
    en     = rounds;
    im     = rounds && !(k == K_INIT && pos == 0);
    xd     = (pos == 0) && (k == K_AD || k == K_PT || k == K_FINAL);
    xk     = (pos == 0) && (k == K_FINAL);
    byp    = !(last && (k == K_INIT || k == K_AD || k == K_FINAL));
    mk     = last && (k == K_INIT || k == K_FINAL);
    cv     = (pos == 0) && (k == K_PT || k == K_FINAL);
    tv     = (k == K_DONE);
    return {rdy, rnd, en, im, xd, xk, byp, mk, cv, tv, 1'b1};
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      bit a;
      int idx, pos, k;
      a = act[m]; idx = m_idx[m]; pos = m_pos[m];
      if (rst) begin
        a = 1'b0; idx = 0; pos = 0;
      end else if (!a) begin
        if (start) begin a = 1'b1; idx = 0; pos = 0; end
      end else begin
        k = seg_kind(idx, nbv[m]);
        if (k == K_WAIT) begin
          if (valid) begin idx = idx + 1; pos = 0; end
        end else begin
          pos = pos + 1;
          if (pos == seg_len(k)) begin
            pos = 0;
            if (k == K_DONE) a = 1'b0;
            else idx = idx + 1;
          end
        end
      end
      act[m] <= a; m_idx[m] <= idx; m_pos[m] <= pos;
    end
  end

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [13:0] e4, e1;
    e4 = exp_vec(act[0], seg_kind(m_idx[0], nbv[0]), m_pos[0]);
    e1 = exp_vec(act[1], seg_kind(m_idx[1], nbv[1]), m_pos[1]);
    checks += 2;
    if (v4 !== e4) begin
      errors++;
      $display("FAIL model_nb4 at %0t: got %h expected %h", $time, v4, e4);
    end
    if (v1 !== e1) begin
      errors++;
      $display("FAIL model_nb1 at %0t: got %h expected %h", $time, v1, e1);
    end
  end

  task automatic run_directed(input int ncyc, input logic hold_valid);
    @(negedge clk);
    start = 1'b1;
    valid = hold_valid;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = 1'b0;
      log4[k] = v4;
      log1[k] = v1;
    end
  endtask

  initial begin
    int rdy_cnt, en_in_wait;
    nbv[0] = 4;
    nbv[1] = 1;
    repeat (3) @(negedge clk);
    chk("reset_vec_nb4", int'(v4), int'(IDLE_VEC));
    chk("reset_vec_nb1", int'(v1), int'(IDLE_VEC));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full message with data_valid tied high.
    run_directed(60, 1'b1);
    for (int k = 1; k <= 60; k++) begin
      chk($sformatf("ready4_c%0d", k), int'(log4[k][13]), int'(k == 13 || k == 20 || k == 27 || k == 34 || k == 41));
      chk($sformatf("cipher4_c%0d", k), int'(log4[k][2]), int'(k == 21 || k == 28 || k == 35 || k == 42));
      chk($sformatf("tag4_c%0d", k), int'(log4[k][1]), int'(k == 54));
      chk($sformatf("busy4_c%0d", k), int'(log4[k][0]), int'(k <= 54));
      chk($sformatf("cipher1_c%0d", k), int'(log1[k][2]), int'(k == 21));
      chk($sformatf("key1_c%0d", k), int'(log1[k][5]), int'(k == 21));
      chk($sformatf("tag1_c%0d", k), int'(log1[k][1]), int'(k == 33));
    end
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("init_mode_c%0d", k), int'(log4[k][7]), int'(k != 1));
      chk($sformatf("init_round_c%0d", k), int'(log4[k][12:9]), k - 1);
    end
    chk("init_keyxor_c12", int'({log4[12][4], log4[12][3]}), 1);
    chk("ad_domsep_c19", int'({log4[19][4], log4[19][3]}), 0);
    chk("ad_round_c19", int'(log4[19][12:9]), 11);
    valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while FINAL is at rc = 5.
    run_directed(47, 1'b1);
    chk("final_rc5_round", int'(log4[47][12:9]), 5);
    chk("final_rc5_enable", int'(log4[47][8]), 1);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy", int'(bsy4), 0);
    chk("rst_enable", int'(en4), 0);
    chk("rst_bypass", int'(byp4), 1);
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    run_directed(60, 1'b1);
    chk("rerun_tag_c54", int'(log4[54][1]), 1);
    chk("rerun_busy_c55", int'(log4[55][0]), 0);
    valid = 1'b0;
    repeat (3) @(negedge clk);

    // Withhold data_valid for 5 cycles in WAIT_AD.
    @(negedge clk);
    start = 1'b1;
    valid = 1'b0;
    rdy_cnt = 0;
    en_in_wait = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      log4[k] = v4;
      if (k <= 18 && v4[13]) begin
        rdy_cnt++;
        if (v4[8]) en_in_wait++;
      end
      valid = (k == 18);
    end
    chk("wait_ad_ready_cycles", rdy_cnt, 6);
    chk("wait_ad_enable", en_in_wait, 0);
    chk("ad_start_enable_c19", int'(log4[19][8]), 1);
    chk("ad_start_round_c19", int'(log4[19][12:9]), 6);
    chk("ad_start_xor_c19", int'(log4[19][6]), 1);

    // Randomized traffic including stray start/valid and occasional resets.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      start = ($urandom_range(7) == 0);
      valid = ($urandom_range(4) < 2);
      if ($urandom_range(699) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    start = 1'b0;
    valid = 1'b0;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
